// File: rtl/csi2_pkg.sv
// Shared CSI-2 receive definitions: data types, depacketizer FSM states,
// header layout and the Hamming ECC parity masks.
package csi2_pkg;

  localparam logic [5:0] DT_FS   = 6'h00;
  localparam logic [5:0] DT_FE   = 6'h01;
  localparam logic [5:0] DT_LS   = 6'h02;
  localparam logic [5:0] DT_LE   = 6'h03;
  localparam logic [5:0] DT_RAW8 = 6'h2A;

  // Data types below this value are short packets.
  localparam logic [5:0] DT_SHORT_LIMIT = 6'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CRC,
    ST_DROP
  } rx_state_e;

  typedef struct packed {
    logic [7:0]  ecc;
    logic [15:0] wc;
    logic [7:0]  di;
  } csi2_hdr_t;

  // Parity bit gi covers the header bits {WC, DI} set in ECC_MASK[gi].
  localparam logic [5:0][23:0] ECC_MASK = {
    24'hEFFC00, 24'hDF03F0, 24'hB8E38E,
    24'h749A6D, 24'hF2555B, 24'hF12CB7
  };

endpackage

// File: rtl/csi2_rx_ecc.sv
// Combinational CSI-2 header ECC generator: 24 header bits {WC, DI} to the
// 6 Hamming parity bits. Usable by both RX checking and TX generation.
module csi2_rx_ecc
  import csi2_pkg::*;
(
  input  logic [23:0] data,
  output logic [5:0]  ecc
);

  for (genvar gi = 0; gi < 6; gi++) begin : g_parity
    assign ecc[gi] = ^(data & ECC_MASK[gi]);
  end

endmodule

// File: rtl/csi2_rx_depacketizer.sv
// CSI-2 2-lane packet decoder that regenerates a CMOS-style fv/lv/dvalid bus.
// Define CSI2_RX_ECC_CHECK_EN to check header ECC and report ecc_err_o.
module csi2_rx_depacketizer
  import csi2_pkg::*;
#(
  parameter logic [1:0] VC       = 2'd0,
  parameter logic [7:0] DT_PIXEL = 8'h2A
) (
  input  logic        byte_clk_i,
  input  logic        reset_i,
  input  logic [15:0] hs_data_i,
  input  logic        hs_valid_i,
  output logic [15:0] pixdata_o,
  output logic        dvalid_o,
  output logic        fv_o,
  output logic        lv_o,
  output logic        pkt_err_o,
  output logic        ecc_err_o
);

  rx_state_e   state_reg;
  logic [7:0]  di_reg;
  logic [7:0]  wc_lo_reg;
  logic [14:0] cnt_reg;
  logic        hs_valid_prev_reg;

  csi2_hdr_t   hdr;
  logic [5:0]  dt;
  logic        vc_match;
  logic        pix_match;
  logic        ecc_bad;
  logic        unused_bits;

  // The full header is only complete while word 1 is on the bus in ST_HDR.
  assign hdr       = {hs_data_i[15:8], hs_data_i[7:0], wc_lo_reg, di_reg};
  assign dt        = hdr.di[5:0];
  assign vc_match  = (hdr.di[7:6] == VC);
  assign pix_match = vc_match && ({2'b00, dt} == DT_PIXEL);

`ifdef CSI2_RX_ECC_CHECK_EN
  logic [5:0] ecc_calc;

  csi2_rx_ecc u_ecc (
    .data ({hdr.wc, hdr.di}),
    .ecc  (ecc_calc)
  );

  assign ecc_bad     = (ecc_calc != hdr.ecc[5:0]);
  assign unused_bits = ^hdr.ecc[7:6];
`else
  assign ecc_bad     = 1'b0;
  assign unused_bits = ^hdr.ecc;
`endif

  always_ff @(posedge byte_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg         <= ST_IDLE;
      di_reg            <= '0;
      wc_lo_reg         <= '0;
      cnt_reg           <= '0;
      // Held high so a packet already in flight at release is skipped.
      hs_valid_prev_reg <= 1'b1;
      pixdata_o         <= '0;
      dvalid_o          <= 1'b0;
      fv_o              <= 1'b0;
      lv_o              <= 1'b0;
      pkt_err_o         <= 1'b0;
      ecc_err_o         <= 1'b0;
    end else begin
      hs_valid_prev_reg <= hs_valid_i;
      dvalid_o          <= 1'b0;
      pkt_err_o         <= 1'b0;
      ecc_err_o         <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (hs_valid_i && !hs_valid_prev_reg) begin
            di_reg    <= hs_data_i[7:0];
            wc_lo_reg <= hs_data_i[15:8];
            state_reg <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (!hs_valid_i) begin
            pkt_err_o <= 1'b1;
            state_reg <= ST_IDLE;
          end else if (ecc_bad) begin
            ecc_err_o <= 1'b1;
            state_reg <= ST_DROP;
          end else if (dt < DT_SHORT_LIMIT) begin
            if (vc_match) begin
              case (dt)
                DT_FS:   fv_o <= 1'b1;
                DT_FE:   fv_o <= 1'b0;
                DT_LS:   lv_o <= 1'b1;
                DT_LE:   lv_o <= 1'b0;
                default: ;
              endcase
            end
            state_reg <= ST_DROP;
          end else if (hdr.wc[0]) begin
            pkt_err_o <= 1'b1;
            state_reg <= ST_DROP;
          end else if (hdr.wc == 16'd0) begin
            state_reg <= ST_CRC;
          end else begin
            cnt_reg   <= hdr.wc[15:1];
            state_reg <= ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          if (!hs_valid_i) begin
            pkt_err_o <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            if (pix_match) begin
              pixdata_o <= hs_data_i;
              dvalid_o  <= 1'b1;
            end
            cnt_reg <= cnt_reg - 15'd1;
            if (cnt_reg == 15'd1) begin
              state_reg <= ST_CRC;
            end
          end
        end

        ST_CRC: begin
          if (!hs_valid_i) begin
            pkt_err_o <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            state_reg <= ST_DROP;
          end
        end

        ST_DROP: begin
          if (!hs_valid_i) begin
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/csi2_rx_depacketizer.md
# csi2_rx_depacketizer

Receive-side CSI-2 packet decoder for the SDI-MIPI bridge. It is the counterpart to the CMOS-to-D-PHY transmit path. The block takes the merged 2-lane byte stream from the D-PHY RX byte-alignment logic, parses short and long packet headers, and regenerates a parallel CMOS-style video bus (fv/lv/dvalid/pixdata) in the byte clock domain. It sits between the D-PHY RX hard IP and the downstream pixel FIFO.

## Interface
Parameters:
- VC, default 0: virtual channel accepted; packets on any other VC are consumed silently.
- DT_PIXEL, default 8'h2A: long-packet data type forwarded as pixels (RAW8).

Ports:
- byte_clk_i, in, 1: byte clock; the only clock.
- reset_i, in, 1: asynchronous, active-high reset.
- hs_data_i, in, 16: lane0 byte in [7:0] (earlier byte), lane1 byte in [15:8].
- hs_valid_i, in, 1: high continuously for one packet; low at least 1 cycle between packets.
- pixdata_o, out, 16: two RAW8 pixels; [7:0] is the first pixel.
- dvalid_o, out, 1: pixdata_o valid.
- fv_o, out, 1: frame valid.
- lv_o, out, 1: line valid.
- pkt_err_o, out, 1: 1-cycle pulse on truncated packet or odd WC.
- ecc_err_o, out, 1: 1-cycle pulse on header ECC mismatch (tied 0 without CSI2_RX_ECC_CHECK_EN).

## Operation
- Header word 0 = {WC[7:0], DI}, word 1 = {ECC, WC[15:8]}. DI[7:6] = VC, DI[5:0] = DT.
- FSM states:
  - IDLE: on hs_valid_i=1, latch word 0 and go to HDR.
  - HDR: latch word 1 and decode.
    - Short packet (DT < 0x10): FS sets fv_o, FE clears fv_o, LS sets lv_o, LE clears lv_o. Other short DTs are ignored. Next state is DROP.
    - Long packet, WC odd: pulse pkt_err_o, go to DROP.
    - Long packet, WC = 0: go to CRC.
    - Otherwise load word counter = WC/2 and go to PAYLOAD.
  - PAYLOAD: each word decrements the counter. If DT == DT_PIXEL and VC matches, the word is registered to pixdata_o with dvalid_o=1; other DTs are consumed with no output. When the counter reaches 1, go to CRC.
  - CRC: consume one word; the CRC is not checked. Go to DROP.
  - DROP: wait for hs_valid_i=0, then go to IDLE. Trailing words are ignored without error.
- hs_valid_i=0 in HDR, PAYLOAD or CRC: pulse pkt_err_o, go to IDLE. fv_o/lv_o keep their values.
- VC mismatch: packet consumed. No fv/lv/dvalid effect, no error.
- The word counter is 15 bits; WC up to 65534 is supported.

## Timing
- Reset values: pixdata_o=0, dvalid_o=0, fv_o=0, lv_o=0, pkt_err_o=0, ecc_err_o=0. FSM returns to IDLE.
- Reset asserted mid-packet aborts immediately. After release, the FSM resynchronises on the next hs_valid_i rising edge. A packet already in progress at release is treated as new (DROP via error path is acceptable; no output corruption).
- Payload latency: input word at edge N appears on pixdata_o/dvalid_o after edge N+1 (1 cycle).
- Short packet: fv_o/lv_o update 1 cycle after header word 1.
- Error pulses are asserted the cycle after the detecting word or the hs_valid_i drop.
- Throughput: 2 bytes per cycle, no backpressure. Downstream must accept dvalid_o every cycle.

## Configuration
- CSI2_RX_ECC_CHECK_EN defined:
  - The 6-bit Hamming ECC over {WC, DI} is computed and compared with ECC[5:0] in HDR.
  - On mismatch: pulse ecc_err_o and go to DROP. No fv/lv/dvalid effect.
  - No single-bit correction.
- CSI2_RX_ECC_CHECK_EN undefined: the ECC byte is ignored and ecc_err_o is tied 0. Latency is unchanged.

## Structure
- Package csi2_pkg holds:
  - DT constants: DT_FS=0x00, DT_FE=0x01, DT_LS=0x02, DT_LE=0x03, DT_RAW8=0x2A.
  - The FSM state enum.
  - A header struct {di, wc, ecc}.
- Sub-module csi2_rx_ecc: combinational 24-bit to 6-bit ECC generator. It is instantiated only under CSI2_RX_ECC_CHECK_EN and is shareable with TX-side checks.

## Test plan
- FS, LS, then a long RAW8 packet with WC=4, payload 0x0201, 0x0403, plus CRC; then LE, FE.
  - fv_o and lv_o rise and fall in order.
  - dvalid_o is high for exactly 2 cycles with pixdata_o 0x0201 then 0x0403.
- Long packet with DT=0x12 and WC=8: dvalid_o stays 0 and no errors occur.
- Long packet with WC=5: pkt_err_o pulses once, dvalid_o stays 0, FSM is back in IDLE after hs_valid_i falls.
- hs_valid_i dropped after 1 of 4 payload words (WC=8):
  - dvalid_o is high for 1 cycle.
  - pkt_err_o pulses.
  - The next LS packet decodes normally.
- With CSI2_RX_ECC_CHECK_EN: LS with one ECC bit flipped gives an ecc_err_o pulse and lv_o stays 0. The correct ECC sets lv_o.
- Packet with VC=1 (parameter VC=0): fully ignored. reset_i asserted mid-payload: all outputs 0 on the next edge.
